// File: rtl/axi4_lite_gpu_fill.sv
// axi4_lite_gpu_fill
//   AXI4-Lite controlled 2D fill engine. The CPU programs origin, size, colour
//   and mode, then writes START; the engine streams one pixel per cycle into a
//   write-only framebuffer port in raster order, clipped to the framebuffer.
// Ports
//   s_axi_ctrl_aclk / s_axi_ctrl_aresetn : clock, async active-low reset
//   s_axi_ctrl_{ar,r,aw,w,b}*             : AXI4-Lite slave, 32-bit data
//   fbuf_en_wr, fbuf_wrea                 : framebuffer enable / write enable
//   fbuf_addr, fbuf_data                  : pixel address (y*FB_WIDTH+x), colour
//   irq                                   : level, STATUS.DONE & CTRL.IRQ_EN
// Register map (addr[4:2]): 0 CTRL, 1 STATUS, 2 ORIGIN, 3 SIZE, 4 COLOR, 5 ID
module axi4_lite_gpu_fill #(
  parameter int          AXI_ADDRESS_WIDTH = 32,
  parameter int          AXI_DATA_WIDTH    = 32,
  parameter int          FBUF_ADDR_WIDTH   = 19,
  parameter int          FBUF_DATA_WIDTH   = 8,
  parameter int          FB_WIDTH          = 640,
  parameter int          FB_HEIGHT         = 480,
  parameter logic [31:0] VERSION           = 32'hffffffff
) (
  input  logic                         s_axi_ctrl_aclk,
  input  logic                         s_axi_ctrl_aresetn,
  input  logic [AXI_ADDRESS_WIDTH-1:0] s_axi_ctrl_araddr,
  input  logic                         s_axi_ctrl_arvalid,
  output logic                         s_axi_ctrl_arready,
  output logic [AXI_DATA_WIDTH-1:0]    s_axi_ctrl_rdata,
  output logic [1:0]                   s_axi_ctrl_rresp,
  output logic                         s_axi_ctrl_rvalid,
  input  logic                         s_axi_ctrl_rready,
  input  logic [AXI_ADDRESS_WIDTH-1:0] s_axi_ctrl_awaddr,
  input  logic                         s_axi_ctrl_awvalid,
  output logic                         s_axi_ctrl_awready,
  input  logic [AXI_DATA_WIDTH-1:0]    s_axi_ctrl_wdata,
  input  logic                         s_axi_ctrl_wvalid,
  output logic                         s_axi_ctrl_wready,
  output logic [1:0]                   s_axi_ctrl_bresp,
  output logic                         s_axi_ctrl_bvalid,
  input  logic                         s_axi_ctrl_bready,
  output logic                         fbuf_en_wr,
  output logic                         fbuf_wrea,
  output logic [FBUF_ADDR_WIDTH-1:0]   fbuf_addr,
  output logic [FBUF_DATA_WIDTH-1:0]   fbuf_data,
  output logic                         irq
);

  localparam int FA = FBUF_ADDR_WIDTH;
  localparam int FD = FBUF_DATA_WIDTH;
  localparam logic [16:0]   FBW17 = 17'(FB_WIDTH);
  localparam logic [16:0]   FBH17 = 17'(FB_HEIGHT);
  localparam logic [FA-1:0] FBWA  = FA'(FB_WIDTH);

  typedef enum logic [1:0] {IDLE, CLIP, RUN} state_t;

  logic clk, rst_n;
  assign clk   = s_axi_ctrl_aclk;
  assign rst_n = s_axi_ctrl_aresetn;

  // only addr[4:2] selects a register
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_ctrl_araddr[AXI_ADDRESS_WIDTH-1:5], s_axi_ctrl_araddr[1:0],
                              s_axi_ctrl_awaddr[AXI_ADDRESS_WIDTH-1:5], s_axi_ctrl_awaddr[1:0]};

  // programmable registers
  logic          mode, irq_en, done;
  logic [15:0]   x0, y0, w, h;
  logic [FD-1:0] color;

  // snapshot taken at START, plus fill counters
  logic [15:0]   s_x0, s_y0, s_w, s_h;
  logic [FD-1:0] s_color;
  logic [16:0]   xe, ye;
  logic [15:0]   x, y;
  logic [FA-1:0] row_base;

  state_t state, state_nxt;
  logic   busy, run;

  // write channel holding registers
  logic                      aw_held, w_held;
  logic [2:0]                aw_idx;
  logic [AXI_DATA_WIDTH-1:0] wdata_q;

  // ---------------- register write decode ----------------
  logic wr_fire, wr_mapped, wr_drop, wr_ok, start_req, clr_done, set_done;
  logic empty, last;

  assign wr_fire   = aw_held & w_held & ~s_axi_ctrl_bvalid;
  assign wr_mapped = (aw_idx <= 3'd5);
  // geometry/colour are frozen while a fill is in progress
  assign wr_drop   = busy & (aw_idx == 3'd2 || aw_idx == 3'd3 || aw_idx == 3'd4);
  assign wr_ok     = wr_fire & wr_mapped & ~wr_drop;
  assign start_req = wr_ok & (aw_idx == 3'd0) & wdata_q[0] & (state == IDLE);
  assign clr_done  = wr_ok & (aw_idx == 3'd1) & wdata_q[1];

  assign empty = (s_w == 16'd0) || (s_h == 16'd0) ||
                 ({1'b0, s_x0} >= FBW17) || ({1'b0, s_y0} >= FBH17);
  assign last  = ({1'b0, x} + 17'd1 == xe) && ({1'b0, y} + 17'd1 == ye);
  assign set_done = (state == CLIP && empty) || (state == RUN && last);

  // ---------------- AXI handshakes ----------------
  logic [31:0] rd_data_nxt;
  logic [1:0]  rd_resp_nxt;

  always_comb begin
    rd_data_nxt = '0;
    rd_resp_nxt = 2'b00;
    case (s_axi_ctrl_araddr[4:2])
      3'd0: rd_data_nxt = {29'd0, irq_en, mode, 1'b0};
      3'd1: rd_data_nxt = {30'd0, done, busy};
      3'd2: rd_data_nxt = {y0, x0};
      3'd3: rd_data_nxt = {h, w};
      3'd4: rd_data_nxt[FD-1:0] = color;
      3'd5: rd_data_nxt = VERSION;
      default: rd_resp_nxt = 2'b10;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_axi_ctrl_arready <= 1'b0;
      s_axi_ctrl_rvalid  <= 1'b0;
      s_axi_ctrl_rdata   <= '0;
      s_axi_ctrl_rresp   <= 2'b00;
      s_axi_ctrl_awready <= 1'b0;
      s_axi_ctrl_wready  <= 1'b0;
      s_axi_ctrl_bvalid  <= 1'b0;
      s_axi_ctrl_bresp   <= 2'b00;
      aw_held            <= 1'b0;
      w_held             <= 1'b0;
      aw_idx             <= '0;
      wdata_q            <= '0;
    end else begin
      // read: one-cycle ARREADY pulse, only with no response pending
      s_axi_ctrl_arready <= s_axi_ctrl_arvalid & ~s_axi_ctrl_arready & ~s_axi_ctrl_rvalid;
      if (s_axi_ctrl_arvalid && s_axi_ctrl_arready) begin
        s_axi_ctrl_rvalid <= 1'b1;
        s_axi_ctrl_rdata  <= rd_data_nxt;
        s_axi_ctrl_rresp  <= rd_resp_nxt;
      end else if (s_axi_ctrl_rvalid && s_axi_ctrl_rready) begin
        s_axi_ctrl_rvalid <= 1'b0;
      end

      // write: AW and W captured independently, blocked while B is pending
      s_axi_ctrl_awready <= s_axi_ctrl_awvalid & ~s_axi_ctrl_awready & ~aw_held & ~s_axi_ctrl_bvalid;
      s_axi_ctrl_wready  <= s_axi_ctrl_wvalid & ~s_axi_ctrl_wready & ~w_held & ~s_axi_ctrl_bvalid;
      if (s_axi_ctrl_awvalid && s_axi_ctrl_awready) begin
        aw_held <= 1'b1;
        aw_idx  <= s_axi_ctrl_awaddr[4:2];
      end
      if (s_axi_ctrl_wvalid && s_axi_ctrl_wready) begin
        w_held  <= 1'b1;
        wdata_q <= s_axi_ctrl_wdata;
      end
      if (wr_fire) begin
        aw_held           <= 1'b0;
        w_held            <= 1'b0;
        s_axi_ctrl_bvalid <= 1'b1;
        s_axi_ctrl_bresp  <= (!wr_mapped || wr_drop) ? 2'b10 : 2'b00;
      end else if (s_axi_ctrl_bvalid && s_axi_ctrl_bready) begin
        s_axi_ctrl_bvalid <= 1'b0;
      end
    end
  end

  // ---------------- register file ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode   <= 1'b0;
      irq_en <= 1'b0;
      done   <= 1'b0;
      x0     <= '0;
      y0     <= '0;
      w      <= '0;
      h      <= '0;
      color  <= '0;
    end else begin
      if (wr_ok) begin
        case (aw_idx)
          3'd0: begin
            mode   <= wdata_q[1];
            irq_en <= wdata_q[2];
          end
          3'd2: {y0, x0} <= wdata_q[31:0];
          3'd3: {h, w}   <= wdata_q[31:0];
          3'd4: color    <= wdata_q[FD-1:0];
          default: ;
        endcase
      end
      // a completion in the same cycle as W1C wins
      done <= set_done | (done & ~clr_done);
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_req) state_nxt = CLIP;
      CLIP: state_nxt = empty ? IDLE : RUN;
      RUN:  if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    run        = (state == RUN);
    fbuf_en_wr = run;
    fbuf_wrea  = run;
    fbuf_addr  = run ? row_base + FA'(x) : '0;
    fbuf_data  = run ? s_color : '0;
    irq        = done & irq_en;
  end

  // ---------------- fill datapath ----------------
  logic [FA+15:0] row_prod;
  assign row_prod = {{FA{1'b0}}, s_y0} * {16'd0, FBWA};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_x0     <= '0;
      s_y0     <= '0;
      s_w      <= '0;
      s_h      <= '0;
      s_color  <= '0;
      xe       <= '0;
      ye       <= '0;
      x        <= '0;
      y        <= '0;
      row_base <= '0;
    end else begin
      if (start_req) begin
        // MODE comes from the same CTRL write that carries START
        s_x0    <= x0;
        s_y0    <= y0;
        s_w     <= wdata_q[1] ? w : 16'd1;
        s_h     <= wdata_q[1] ? h : 16'd1;
        s_color <= color;
      end
      if (state == CLIP) begin
        xe       <= ({1'b0, s_x0} + {1'b0, s_w} > FBW17) ? FBW17 : {1'b0, s_x0} + {1'b0, s_w};
        ye       <= ({1'b0, s_y0} + {1'b0, s_h} > FBH17) ? FBH17 : {1'b0, s_y0} + {1'b0, s_h};
        x        <= s_x0;
        y        <= s_y0;
        row_base <= row_prod[FA-1:0];
      end
      if (state == RUN) begin
        if ({1'b0, x} + 17'd1 == xe) begin
          x        <= s_x0;
          y        <= y + 16'd1;
          row_base <= row_base + FBWA;
        end else begin
          x <= x + 16'd1;
        end
      end
    end
  end

endmodule
